// File: rtl/genfifo_pkg.sv
// Shared constants and types for the single- and dual-clock FIFO family.
package genfifo_pkg;

  localparam int GENFIFO_ADDR_WIDTH    = 4;
  localparam int GENFIFO_DATA_WIDTH    = 8;
  localparam int GENFIFO_AEMPTY_THRESH = 2;

  // Default almost-full point sits two words below full.
  function automatic int genfifo_afull_default(input int aw);
    return (1 << aw) - 2;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } genfifo_flags_t;

endpackage

// File: rtl/genfifo_sc_ram.sv
// Single-clock storage: registered write, read port combinational (GENFIFO_FWFT_EN)
// or registered with a resettable output register (default).
module genfifo_sc_ram
  import genfifo_pkg::*;
#(
  parameter int ADDR_WIDTH = GENFIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH = GENFIFO_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage is deliberately not reset; the control logic keeps stale words off dout.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

`ifdef GENFIFO_FWFT_EN
  logic w_unused;
  assign w_unused = &{1'b0, i_rst, i_re};
  assign o_rdata  = r_mem[i_raddr];
`else
  logic [DATA_WIDTH-1:0] r_rdata;
  always_ff @(posedge i_clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
`endif

endmodule

// File: rtl/genfifo_sc.sv
// Single-clock FIFO: pointers, occupancy count, flags and error pulses.
// Define GENFIFO_FWFT_EN for first-word-fall-through reads; default is registered read.
module genfifo_sc
  import genfifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = GENFIFO_ADDR_WIDTH,
  parameter int DATA_WIDTH    = GENFIFO_DATA_WIDTH,
  parameter int AFULL_THRESH  = genfifo_afull_default(ADDR_WIDTH),
  parameter int AEMPTY_THRESH = GENFIFO_AEMPTY_THRESH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic [DATA_WIDTH-1:0] i_di,
  input  logic                  i_re,
  output logic [DATA_WIDTH-1:0] o_dout,
  output logic                  o_rd_valid,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_afull,
  output logic                  o_aempty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int                CW        = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH  = CW'(1 << ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] LP_ONE    = CW'(1);
  localparam logic [ADDR_WIDTH:0] LP_AFULL  = CW'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] LP_AEMPTY = CW'(AEMPTY_THRESH);

  logic [ADDR_WIDTH:0]   r_wptr, r_rptr, r_count;
  logic                  r_ovf, r_udf;
  logic                  w_wr_acc, w_rd_acc;
  logic [DATA_WIDTH-1:0] w_rdata;
  genfifo_flags_t        w_flags;

  // Flags come from the count register only, never from we/re.
  always_comb begin
    w_flags        = '0;
    w_flags.full   = (r_count == LP_DEPTH);
    w_flags.empty  = (r_count == '0);
    w_flags.afull  = (r_count >= LP_AFULL);
    w_flags.aempty = (r_count <= LP_AEMPTY);
  end

  assign w_wr_acc = i_we & ~w_flags.full  & ~i_rst;
  assign w_rd_acc = i_re & ~w_flags.empty & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + LP_ONE;
      if (w_rd_acc) r_rptr <= r_rptr + LP_ONE;
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + LP_ONE;
        2'b01:   r_count <= r_count - LP_ONE;
        default: r_count <= r_count;
      endcase
      r_ovf <= i_we & w_flags.full;
      r_udf <= i_re & w_flags.empty;
    end
  end

  genfifo_sc_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_wr_acc),
    .i_waddr (r_wptr[ADDR_WIDTH-1:0]),
    .i_wdata (i_di),
    .i_re    (w_rd_acc),
    .i_raddr (r_rptr[ADDR_WIDTH-1:0]),
    .o_rdata (w_rdata)
  );

`ifdef GENFIFO_FWFT_EN
  assign o_dout     = w_flags.empty ? '0 : w_rdata;
  assign o_rd_valid = ~w_flags.empty;
`else
  logic r_rd_valid;
  always_ff @(posedge i_clk) begin
    if (i_rst) r_rd_valid <= 1'b0;
    else       r_rd_valid <= w_rd_acc;
  end
  assign o_dout     = w_rdata;
  assign o_rd_valid = r_rd_valid;
`endif

  assign o_full      = w_flags.full;
  assign o_empty     = w_flags.empty;
  assign o_afull     = w_flags.afull;
  assign o_aempty    = w_flags.aempty;
  assign o_count     = r_count;
  assign o_overflow  = r_ovf;
  assign o_underflow = r_udf;

endmodule
